// File: rtl/press_sequencer_if.sv
// Command/status bundle of the push-button waveform generator.
// The master issues press commands; the slave (press_sequencer) drives the button level and status.
interface press_sequencer_if;
    logic       cmd_valid;
    logic       cmd_long;
    logic       cmd_ready;
    logic       push_button;
    logic       busy;
    logic       done;
    logic [7:0] press_count;

    modport master (
        output cmd_valid, cmd_long,
        input  cmd_ready, push_button, busy, done, press_count
    );

    modport slave (
        input  cmd_valid, cmd_long,
        output cmd_ready, push_button, busy, done, press_count
    );
endinterface

// File: rtl/press_sequencer.sv
// Command-driven push-button waveform generator: one timed press plus a fixed release gap per command.
// Define BOUNCE_EMU_EN to add contact-bounce phases before and after every hold.
module press_sequencer #(
`ifdef BOUNCE_EMU_EN
    parameter int BOUNCE_N          = 4,
    parameter int BOUNCE_T          = 5,
`endif
    parameter int CLK_PER_MS        = 1,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int SHORT_HOLD_T      = 500,
    parameter int LONG_MARGIN_T     = 500,
    parameter int GAP_T             = 1000
) (
    input  logic             clk,
    input  logic             rst,
    press_sequencer_if.slave bus
);
    localparam int SHORT_CYC = SHORT_HOLD_T * CLK_PER_MS;
    localparam int LONG_CYC  = (SWITCH_MODE_MIN_T + LONG_MARGIN_T) * CLK_PER_MS;
    localparam int GAP_CYC   = GAP_T * CLK_PER_MS;
`ifdef BOUNCE_EMU_EN
    localparam int PHASE_CYC = BOUNCE_T * CLK_PER_MS;
    localparam int MAX_LG    = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int MAX_CYC   = (MAX_LG > PHASE_CYC) ? MAX_LG : PHASE_CYC;
    localparam int PH_W      = (BOUNCE_N > 1) ? $clog2(BOUNCE_N) : 1;
`else
    localparam int MAX_CYC   = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
`endif
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    // Timing must stay compatible with the receiving controller's debounce and long-press detection.
    if (!(SHORT_HOLD_T > DEBOUNCE_P && SHORT_HOLD_T < SWITCH_MODE_MIN_T && GAP_T > DEBOUNCE_P))
    begin : g_bad_timing
        $error("press_sequencer: hold/gap timing incompatible with receiver debounce");
    end
`ifdef BOUNCE_EMU_EN
    if (BOUNCE_N < 2 || (BOUNCE_N % 2) != 0 || BOUNCE_N * BOUNCE_T >= DEBOUNCE_P)
    begin : g_bad_bounce
        $error("press_sequencer: bounce train must be even, >=2 phases and shorter than debounce");
    end
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
`ifdef BOUNCE_EMU_EN
        , S_BOUNCE_IN
        , S_BOUNCE_OUT
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_q, push_d;
    logic               done_q, done_d;
    logic [7:0]         count_q, count_d;
    logic               expire;
`ifdef BOUNCE_EMU_EN
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               long_q, long_d;
`endif

    assign expire = (cnt_q == CNT_W'(1));

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        push_d  = push_q;
        done_d  = 1'b0;
        count_d = count_q;
`ifdef BOUNCE_EMU_EN
        phase_d = phase_q;
        long_d  = long_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (bus.cmd_valid) begin
                    push_d = 1'b1;
`ifdef BOUNCE_EMU_EN
                    long_d  = bus.cmd_long;
                    state_d = S_BOUNCE_IN;
                    cnt_d   = CNT_W'(PHASE_CYC);
                    phase_d = '0;
`else
                    state_d = S_HOLD;
                    cnt_d   = bus.cmd_long ? CNT_W'(LONG_CYC) : CNT_W'(SHORT_CYC);
`endif
                end
            end
`ifdef BOUNCE_EMU_EN
            // Bounce levels simply alternate; the train starts 1 going in and 0 going out.
            S_BOUNCE_IN: if (expire) begin
                cnt_d = CNT_W'(PHASE_CYC);
                if (phase_q == PH_W'(BOUNCE_N - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = long_q ? CNT_W'(LONG_CYC) : CNT_W'(SHORT_CYC);
                    push_d  = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                    push_d  = ~push_q;
                end
            end
            S_BOUNCE_OUT: if (expire) begin
                cnt_d = CNT_W'(PHASE_CYC);
                if (phase_q == PH_W'(BOUNCE_N - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(GAP_CYC);
                    push_d  = 1'b0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                    push_d  = ~push_q;
                end
            end
`endif
            S_HOLD: if (expire) begin
                push_d = 1'b0;
`ifdef BOUNCE_EMU_EN
                state_d = S_BOUNCE_OUT;
                cnt_d   = CNT_W'(PHASE_CYC);
                phase_d = '0;
`else
                state_d = S_GAP;
                cnt_d   = CNT_W'(GAP_CYC);
`endif
            end
            S_GAP: if (expire) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                count_d = count_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
                push_d  = 1'b0;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

`ifdef BOUNCE_EMU_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            long_q  <= long_d;
        end
    end
`endif

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.push_button = push_q;
    assign bus.done        = done_q;
    assign bus.press_count = count_q;
endmodule

// File: tb/tb_press_sequencer.sv
// Self-checking bench for press_sequencer: randomized commands against a segment-based waveform model.
// A second, fast-timed instance exercises the press_count wrap within a short run.
module tb_press_sequencer;
    localparam int CPM    = 1;
    localparam int SW     = 5000;
    localparam int SHORT  = 500;
    localparam int MARGIN = 500;
    localparam int GAP    = 1000;
`ifdef BOUNCE_EMU_EN
    localparam int BN     = 4;
    localparam int BT     = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    press_sequencer_if bus ();
    press_sequencer_if fbus ();

    press_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    press_sequencer #(
`ifdef BOUNCE_EMU_EN
        .BOUNCE_N          (2),
        .BOUNCE_T          (1),
`endif
        .CLK_PER_MS        (1),
        .DEBOUNCE_P        (3),
        .SWITCH_MODE_MIN_T (8),
        .SHORT_HOLD_T      (4),
        .LONG_MARGIN_T     (1),
        .GAP_T             (4)
    ) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (fbus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int model_count = 0;

    function automatic int bounce_len();
`ifdef BOUNCE_EMU_EN
        return BN * BT * CPM;
`else
        return 0;
`endif
    endfunction

    function automatic int hold_len(input bit lng);
        return (lng ? (SW + MARGIN) : SHORT) * CPM;
    endfunction

    function automatic int total_len(input bit lng);
        return 2 * bounce_len() + hold_len(lng) + GAP * CPM;
    endfunction

    // Expected level in cycle k after the acceptance edge (cycle 1 is the first cycle of the press).
    function automatic logic exp_level(input int k, input bit lng);
        int t;
        t = k - 1;
        if (t < 0) return 1'b0;
`ifdef BOUNCE_EMU_EN
        if (t < bounce_len()) return ((t / (BT * CPM)) % 2) == 0;
`endif
        t = t - bounce_len();
        if (t < hold_len(lng)) return 1'b1;
        t = t - hold_len(lng);
`ifdef BOUNCE_EMU_EN
        if (t < bounce_len()) return ((t / (BT * CPM)) % 2) == 1;
`endif
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.push_button !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.press_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_held: push=%b busy=%b done=%b count=%0d ready=%b, want 0 0 0 0 1",
                     bus.push_button, bus.busy, bus.done, bus.press_count, bus.cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 5;
        if (bus.push_button !== 1'b0) begin n_bad++; $display("FAIL reset_push: got %b want 0", bus.push_button); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.press_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.press_count); end
        if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        model_count = 0;
    endtask

    // One full command. preloaded: cmd_valid is already high from the previous done cycle.
    // noise_at: cycle with a one-cycle cmd_valid pulse while busy. chain_from: hold cmd_valid from there on.
    task automatic do_press(input string tag, input bit lng, input bit preloaded,
                            input int noise_at, input int chain_from, input bit chain_long);
        int total;
        int bad_w, bad_b, bad_d, bad_r, bad_c, first_w;
        logic first_got, first_want;
        logic [7:0] exp_cnt, last_cnt;
        total = total_len(lng);
        bad_w = 0; bad_b = 0; bad_d = 0; bad_r = 0; bad_c = 0; first_w = -1;
        first_got = 1'b0; first_want = 1'b0; last_cnt = 8'd0;
        if (!preloaded) begin
            @(negedge clk);
            n_cmp++;
            if (bus.cmd_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s accept_ready: got %b want 1", tag, bus.cmd_ready);
            end
            bus.cmd_valid = 1'b1;
            bus.cmd_long  = lng;
        end
        @(posedge clk);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            exp_cnt = (k == total + 1) ? 8'(model_count + 1) : 8'(model_count);
            if (bus.push_button !== exp_level(k, lng)) begin
                if (first_w < 0) begin
                    first_w = k; first_got = bus.push_button; first_want = exp_level(k, lng);
                end
                bad_w++;
            end
            if (bus.busy !== 1'(k <= total)) bad_b++;
            if (bus.cmd_ready !== 1'(k > total)) bad_r++;
            if (bus.done !== 1'(k == total + 1)) bad_d++;
            if (bus.press_count !== exp_cnt) begin bad_c++; last_cnt = bus.press_count; end
            bus.cmd_valid = (k == noise_at) || (chain_from > 0 && k >= chain_from);
            bus.cmd_long  = (chain_from > 0 && k >= chain_from) ? chain_long : 1'($urandom);
        end
        model_count = (model_count + 1) % 256;
        n_cmp += 5;
        if (bad_w != 0) begin
            n_bad++;
            $display("FAIL %s push_button: %0d wrong cycles, first at cycle %0d got %b want %b",
                     tag, bad_w, first_w, first_got, first_want);
        end
        if (bad_b != 0) begin n_bad++; $display("FAIL %s busy: %0d cycles differ from want (1 for cycles 1..%0d)", tag, bad_b, total); end
        if (bad_r != 0) begin n_bad++; $display("FAIL %s cmd_ready: %0d cycles differ from want (1 only at cycle %0d)", tag, bad_r, total + 1); end
        if (bad_d != 0) begin n_bad++; $display("FAIL %s done: %0d cycles differ from want (pulse at cycle %0d)", tag, bad_d, total + 1); end
        if (bad_c != 0) begin n_bad++; $display("FAIL %s press_count: %0d cycles wrong, last got %0d want %0d at end", tag, bad_c, last_cnt, model_count); end
    endtask

    task automatic test_short();
        do_press("short", 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_long();
        do_press("long", 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_press("b2b_first", 1'b0, 1'b0, 200, 1400, 1'b0);
        do_press("b2b_second", 1'b0, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        bit lng [5];
        bit ch  [5];
        bit pre;
        int total;
        for (int i = 0; i < 5; i++) begin
            lng[i] = ($urandom_range(0, 3) == 0);
            ch[i]  = 1'($urandom_range(0, 1));
        end
        ch[4] = 1'b0;
        pre = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total = total_len(lng[i]);
            if (!pre) repeat ($urandom_range(0, 4)) @(negedge clk);
            do_press($sformatf("rand%0d", i), lng[i], pre, int'($urandom_range(1, total)),
                     ch[i] ? int'($urandom_range(1, total)) : 0, (i < 4) ? lng[i + 1] : 1'b0);
            pre = ch[i];
        end
    endtask

    // Fast instance: short presses back to back until press_count wraps.
    task automatic test_wrap();
        int period, cyc, dones, last, bad_gap, cnt255, cnt0, budget;
`ifdef BOUNCE_EMU_EN
        period = 2 * (2 * 1) + 4 + 4 + 1;
`else
        period = 4 + 4 + 1;
`endif
        cyc = 0; dones = 0; last = 0; bad_gap = 0; cnt255 = -1; cnt0 = -1;
        budget = 256 * period + 100;
        @(negedge clk);
        fbus.cmd_valid = 1'b1;
        fbus.cmd_long  = 1'b0;
        while (dones < 256 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (fbus.done === 1'b1) begin
                dones++;
                if (cyc - last != period) bad_gap++;
                last = cyc;
                if (dones == 255) cnt255 = int'(fbus.press_count);
                if (dones == 256) begin
                    cnt0 = int'(fbus.press_count);
                    fbus.cmd_valid = 1'b0;
                end
            end
        end
        fbus.cmd_valid = 1'b0;
        n_cmp += 4;
        if (dones != 256) begin n_bad++; $display("FAIL wrap_timeout: got %0d done pulses want 256 within %0d cycles", dones, budget); end
        if (bad_gap != 0) begin n_bad++; $display("FAIL wrap_spacing: %0d done intervals differ from want %0d cycles", bad_gap, period); end
        if (cnt255 != 255) begin n_bad++; $display("FAIL wrap_count_255: got %0d want 255", cnt255); end
        if (cnt0 != 0) begin n_bad++; $display("FAIL wrap_count_0: got %0d want 0", cnt0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        int bad_after;
        bad_after = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_long  = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        n_cmp++;
        if (bus.push_button !== 1'b1) begin n_bad++; $display("FAIL midhold_pre: push got %b want 1", bus.push_button); end
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.push_button !== 1'b0) begin n_bad++; $display("FAIL midhold_async_drop: push got %b want 0 before any clk edge", bus.push_button); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midhold_async_busy: got %b want 0", bus.busy); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_count = 0;
        @(negedge clk);
        n_cmp += 2;
        if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midhold_ready: got %b want 1", bus.cmd_ready); end
        if (bus.press_count !== 8'd0) begin n_bad++; $display("FAIL midhold_count: got %0d want 0", bus.press_count); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.push_button !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad_after++;
        end
        n_cmp++;
        if (bad_after != 0) begin n_bad++; $display("FAIL midhold_lost: %0d cycles with push/busy/done set, want 0", bad_after); end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_long   = 1'b0;
        fbus.cmd_valid = 1'b0;
        fbus.cmd_long  = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
